// File: rtl/psw_debounce.sv
// N-channel push-switch conditioner: two-flop synchroniser, debounce filter,
// press/release edge pulses and an optional per-channel auto-repeat engine.
module psw_debounce #(
  parameter int CHANNELS      = 5,
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_RATE   = 8,
  parameter int CNT_W         = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [CHANNELS-1:0] repeat_en_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic                any_o
);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  localparam logic             RELEASED_PIN = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST    = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] release_q;
  logic                any_q;

  // Reset loads the released pin level so no false press follows reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= {CHANNELS{RELEASED_PIN}};
      sync2_q <= {CHANNELS{RELEASED_PIN}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic             lvl_d;
    logic             press_d;
    logic             release_d;
    logic             rise;
    logic             fall;

    always_comb begin
      dcnt_d = '0;
      lvl_d  = level_q[gi];
      if (pressed[gi] != level_q[gi]) begin
        if (dcnt_q == STABLE_LAST) begin
          lvl_d = ~level_q[gi];
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
    end

    assign rise        = lvl_d & ~level_q[gi];
    assign fall        = ~lvl_d & level_q[gi];
    assign level_d[gi] = lvl_d;

    // A release always beats a repeat terminal count on the same edge.
    always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          rcnt_d = '0;
          if (rise) begin
            press_d = 1'b1;
            if (repeat_en_i[gi]) begin
              state_d = RPT_DELAY;
            end
          end else if (fall) begin
            release_d = 1'b1;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (fall) begin
            release_d = 1'b1;
            state_d   = RPT_IDLE;
            rcnt_d    = '0;
          end else if (!repeat_en_i[gi]) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == ((state_q == RPT_DELAY) ? DELAY_LAST : RATE_LAST)) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            state_d = RPT_REPEAT;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dcnt_q        <= '0;
        rcnt_q        <= '0;
        state_q       <= RPT_IDLE;
        level_q[gi]   <= 1'b0;
        press_q[gi]   <= 1'b0;
        release_q[gi] <= 1'b0;
      end else begin
        dcnt_q        <= dcnt_d;
        rcnt_q        <= rcnt_d;
        state_q       <= state_d;
        level_q[gi]   <= lvl_d;
        press_q[gi]   <= press_d;
        release_q[gi] <= release_d;
      end
    end
  end

  // Taken from the next-state so ANY moves on the same edge as LEVEL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |level_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign any_o     = any_q;

endmodule

// File: tb/tb_psw_debounce.sv
// Self-checking bench for psw_debounce: hand-derived vector table, directed
// repeat/reset sequences, then random pins checked against an event model.
module tb_psw_debounce;

  localparam int N  = 5;
  localparam int S  = 4;
  localparam int RD = 16;
  localparam int RR = 8;
  localparam logic [N-1:0] IDLE_PINS = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] repEn;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic         any;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  psw_debounce #(
    .CHANNELS(N), .ACTIVE_LOW(1), .STABLE_CYCLES(S),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raw_i(raw), .repeat_en_i(repEn),
    .level_o(level), .press_o(press), .release_o(rel), .any_o(any)
  );

  // Reference model: pins reach the filter two edges late; a level flips
  // after S consecutive disagreeing edges; repeats are timed from the press.
  logic [N-1:0] syncQ[$];
  logic [N-1:0] mLevel, mPress, mRel;
  logic         mAny;
  int           run[N];
  int           t0[N];
  bit           armed[N];
  int           cyc = 0;

  task automatic modelReset();
    syncQ.delete();
    syncQ.push_back('0);
    syncQ.push_back('0);
    mLevel = '0;
    mPress = '0;
    mRel   = '0;
    mAny   = 1'b0;
    for (int c = 0; c < N; c++) begin
      run[c]   = 0;
      armed[c] = 0;
      t0[c]    = 0;
    end
  endtask

  task automatic modelStep(input logic r, input logic [N-1:0] rw, input logic [N-1:0] en);
    logic [N-1:0] p;
    if (r) begin
      modelReset();
      return;
    end
    p = syncQ.pop_front();
    syncQ.push_back(~rw);
    mPress = '0;
    mRel   = '0;
    for (int c = 0; c < N; c++) begin
      bit rise;
      bit fall;
      int d;
      rise = 0;
      fall = 0;
      if (p[c] != mLevel[c]) begin
        run[c]++;
        if (run[c] == S) begin
          run[c]    = 0;
          mLevel[c] = p[c];
          rise      = p[c];
          fall      = !p[c];
        end
      end else begin
        run[c] = 0;
      end
      if (rise) begin
        mPress[c] = 1'b1;
        armed[c]  = en[c];
        t0[c]     = cyc;
      end else if (fall) begin
        mRel[c]  = 1'b1;
        armed[c] = 0;
      end else if (armed[c]) begin
        if (!en[c]) begin
          armed[c] = 0;
        end else begin
          d = cyc - t0[c];
          if (d >= RD && ((d - RD) % RR) == 0) mPress[c] = 1'b1;
        end
      end
    end
    mAny = |mLevel;
    cyc++;
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rw, input logic [N-1:0] en);
    rst   = r;
    raw   = rw;
    repEn = en;
    @(posedge clk);
    modelStep(r, rw, en);
    #1;
  endtask

  task automatic checkOutput(input string name, input int edgeNum,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s edge %0d: got %0h expected %0h", name, edgeNum, act, exp);
    end
  endtask

  task automatic resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, IDLE_PINS, '0);
  endtask

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic [N-1:0] expLevel;
    logic [N-1:0] expPress;
    logic [N-1:0] expRel;
    logic         expAny;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [N-1:0] expP;
    logic [N-1:0] expL;
    logic [N-1:0] rw;
    logic [N-1:0] en;
    logic         r;

    modelReset();
    $display("[TB] start");

    // ch0 press/hold/release with a 3-cycle glitch on ch1 at the start.
    for (int e = 0; e < 17; e++) begin
      vecs[e].raw      = (e <= 2) ? 5'b11100 : ((e <= 9) ? 5'b11110 : 5'b11111);
      vecs[e].en       = '0;
      vecs[e].expLevel = (e >= 5 && e <= 14) ? 5'b00001 : 5'b00000;
      vecs[e].expPress = (e == 5) ? 5'b00001 : 5'b00000;
      vecs[e].expRel   = (e == 15) ? 5'b00001 : 5'b00000;
      vecs[e].expAny   = (e >= 5 && e <= 14);
    end

    resetDut();
    checkOutput("reset_level", -1, 32'(level), 32'h0);
    checkOutput("reset_press", -1, 32'(press), 32'h0);
    checkOutput("reset_release", -1, 32'(rel), 32'h0);
    checkOutput("reset_any", -1, 32'(any), 32'h0);

    for (int e = 0; e < 17; e++) begin
      applyStimulus(1'b0, vecs[e].raw, vecs[e].en);
      checkOutput("tbl_level", e, 32'(level), 32'(vecs[e].expLevel));
      checkOutput("tbl_press", e, 32'(press), 32'(vecs[e].expPress));
      checkOutput("tbl_release", e, 32'(rel), 32'(vecs[e].expRel));
      checkOutput("tbl_any", e, 32'(any), 32'(vecs[e].expAny));
    end

    // ch2 auto-repeat while held, then release.
    resetDut();
    for (int e = 0; e <= 80; e++) begin
      applyStimulus(1'b0, (e < 60) ? 5'b11011 : 5'b11111, 5'b00100);
      checkOutput("rpt_press2", e, 32'(press[2]),
                  32'(e == 5 || e == 21 || e == 29 || e == 37 || e == 45 || e == 53 || e == 61));
      checkOutput("rpt_release2", e, 32'(rel[2]), 32'(e == 65));
    end
    checkOutput("rpt_level2_end", 80, 32'(level[2]), 32'h0);

    // ch3 repeat enable dropped at edge 25 while held.
    resetDut();
    for (int e = 0; e <= 55; e++) begin
      applyStimulus(1'b0, (e < 41) ? 5'b10111 : 5'b11111, (e < 25) ? 5'b01000 : 5'b00000);
      checkOutput("drop_press3", e, 32'(press[3]), 32'(e == 5 || e == 21));
      checkOutput("drop_level3", e, 32'(level[3]), 32'(e >= 5 && e < 46));
      checkOutput("drop_release3", e, 32'(rel[3]), 32'(e == 46));
    end

    // ch0+ch4 together (only ch0 repeats), reset mid-hold, fresh press after.
    resetDut();
    for (int e = 0; e <= 60; e++) begin
      r = (e == 31 || e == 32);
      applyStimulus(r, 5'b01110, 5'b00001);
      expP = '0;
      expP[0] = (e == 5 || e == 21 || e == 29 || e == 38 || e == 54);
      expP[4] = (e == 5 || e == 38);
      expL = ((e >= 5 && e <= 30) || e >= 38) ? 5'b10001 : 5'b00000;
      checkOutput("sim_press", e, 32'(press), 32'(expP));
      checkOutput("sim_level", e, 32'(level), 32'(expL));
      checkOutput("sim_release", e, 32'(rel), 32'h0);
      checkOutput("sim_any", e, 32'(any), 32'(expL != 0));
    end

    // Random pins, enables and occasional reset against the model.
    resetDut();
    rw = IDLE_PINS;
    en = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, (i < 1500) ? 9 : 39) == 0) rw[c] = ~rw[c];
        if ($urandom_range(0, 63) == 0) en[c] = ~en[c];
      end
      r = ($urandom_range(0, 799) == 0);
      applyStimulus(r, rw, en);
      checkOutput("rnd_level", i, 32'(level), 32'(mLevel));
      checkOutput("rnd_press", i, 32'(press), 32'(mPress));
      checkOutput("rnd_release", i, 32'(rel), 32'(mRel));
      checkOutput("rnd_any", i, 32'(any), 32'(mAny));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
